// File: rtl/rtx_timeout_scheduler_pkg.sv
// rtx_timeout_scheduler_pkg: shared FSM encoding, default widths and the flow-id width helper.
package rtx_timeout_scheduler_pkg;
    typedef enum logic {SCAN = 1'b0, PEND = 1'b1} state_t;
    localparam int DEF_TIME_W = 32;
    localparam int DEF_TIMER_W = 16;
    function automatic int clogb2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/rtx_timeout_scheduler_timer_bank.sv
// rtx_timeout_scheduler_timer_bank: per-flow armed bits and absolute deadlines, with a
// combinational wrap-safe expiry check of the flow selected by rd_ptr.
module rtx_timeout_scheduler_timer_bank
    import rtx_timeout_scheduler_pkg::*;
#(
    parameter int NUM_FLOWS = 16,
    parameter int FLOW_ID_W = clogb2(NUM_FLOWS),
    parameter int TIME_W = DEF_TIME_W,
    parameter int TIMER_W = DEF_TIMER_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TIME_W-1:0]    now,
    input  logic                 set_valid,
    input  logic [FLOW_ID_W-1:0] set_flow_id,
    input  logic [TIMER_W-1:0]   set_timer_amnt,
    input  logic                 clr_valid,
    input  logic [FLOW_ID_W-1:0] clr_flow_id,
    input  logic                 ack_valid,
    input  logic [FLOW_ID_W-1:0] ack_flow_id,
    input  logic [FLOW_ID_W-1:0] rd_ptr,
    output logic                 rd_expired,
    output logic [NUM_FLOWS-1:0] armed_vec
);
    logic [TIME_W-1:0] deadline [NUM_FLOWS];
    logic [NUM_FLOWS-1:0] armed;
    logic [TIME_W-1:0] diff;

    // A set always wins over a disarm or an accepted-timeout clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= '0;
            for (int k = 0; k < NUM_FLOWS; k++) deadline[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_FLOWS; k++) begin
                if (set_valid && set_flow_id == FLOW_ID_W'(k)) begin
                    armed[k] <= 1'b1;
                    deadline[k] <= now + TIME_W'(set_timer_amnt);
                end else if ((clr_valid && clr_flow_id == FLOW_ID_W'(k)) ||
                             (ack_valid && ack_flow_id == FLOW_ID_W'(k))) begin
                    armed[k] <= 1'b0;
                end
            end
        end
    end

    // Expired once now has reached the deadline, judged by the sign of the modular difference.
    always_comb begin
        diff = now - deadline[rd_ptr];
        rd_expired = armed[rd_ptr] && !diff[TIME_W-1];
    end

    assign armed_vec = armed;
endmodule

// File: rtl/rtx_timeout_scheduler.sv
// rtx_timeout_scheduler: round-robin scan of the timer bank, raising one timeout
// request per expired flow over a valid/ready handshake.
module rtx_timeout_scheduler
    import rtx_timeout_scheduler_pkg::*;
#(
    parameter int NUM_FLOWS = 16,
    parameter int FLOW_ID_W = clogb2(NUM_FLOWS),
    parameter int TIME_W = DEF_TIME_W,
    parameter int TIMER_W = DEF_TIMER_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TIME_W-1:0]    now,
    input  logic                 en,
    input  logic                 set_valid,
    input  logic [FLOW_ID_W-1:0] set_flow_id,
    input  logic [TIMER_W-1:0]   set_timer_amnt,
    input  logic                 clr_valid,
    input  logic [FLOW_ID_W-1:0] clr_flow_id,
    output logic                 to_valid,
    output logic [FLOW_ID_W-1:0] to_flow_id,
    input  logic                 to_ready,
    output logic [31:0]          expired_cnt,
    output logic [NUM_FLOWS-1:0] armed_vec
);
    state_t state, state_nx;
    logic [FLOW_ID_W-1:0] ptr, ptr_nx, fid, fid_nx;
    logic [31:0] cnt, cnt_nx;
    logic rearm, rearm_nx, rd_expired, hit, set_pend, ack_valid;

    rtx_timeout_scheduler_timer_bank #(
        .NUM_FLOWS(NUM_FLOWS), .FLOW_ID_W(FLOW_ID_W), .TIME_W(TIME_W), .TIMER_W(TIMER_W)
    ) u_bank (
        .clk(clk), .rst(rst), .now(now),
        .set_valid(set_valid), .set_flow_id(set_flow_id), .set_timer_amnt(set_timer_amnt),
        .clr_valid(clr_valid), .clr_flow_id(clr_flow_id),
        .ack_valid(ack_valid), .ack_flow_id(fid),
        .rd_ptr(ptr), .rd_expired(rd_expired), .armed_vec(armed_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SCAN;
            ptr <= '0;
            fid <= '0;
            cnt <= '0;
            rearm <= 1'b0;
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            fid <= fid_nx;
            cnt <= cnt_nx;
            rearm <= rearm_nx;
        end
    end

    // A flow touched by set/clr in the visiting cycle is skipped; its new state is seen next lap.
    always_comb begin
        state_nx = state;
        ptr_nx = ptr;
        fid_nx = fid;
        cnt_nx = cnt;
        rearm_nx = rearm;
        hit = (set_valid && set_flow_id == ptr) || (clr_valid && clr_flow_id == ptr);
        set_pend = set_valid && set_flow_id == fid;
        ack_valid = 1'b0;
        if (state == SCAN) begin
            if (en) begin
                ptr_nx = ptr + 1'b1;
                state_nx = (rd_expired && !hit) ? PEND : SCAN;
                fid_nx = (rd_expired && !hit) ? ptr : fid;
            end
        end else begin
            rearm_nx = rearm || set_pend;
            if (to_ready) begin
                state_nx = SCAN;
                cnt_nx = cnt + 32'd1;
                rearm_nx = 1'b0;
                ack_valid = !rearm;
            end
        end
    end

    assign to_valid = (state == PEND);
    assign to_flow_id = fid;
    assign expired_cnt = cnt;
endmodule

// File: tb/tb_rtx_timeout_scheduler.sv
// tb_rtx_timeout_scheduler: directed test-plan steps plus a random phase, every cycle
// checked against a behavioural model of the flow table and request queue.
module tb_rtx_timeout_scheduler;
    localparam int N = 4;
    localparam int IW = 2;
    localparam int TW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst, en, set_valid, clr_valid, to_ready, to_valid;
    logic [TW-1:0] now;
    logic [IW-1:0] set_flow_id, clr_flow_id, to_flow_id;
    logic [AW-1:0] set_timer_amnt;
    logic [31:0] expired_cnt;
    logic [N-1:0] armed_vec;

    rtx_timeout_scheduler #(.NUM_FLOWS(N), .FLOW_ID_W(IW), .TIME_W(TW), .TIMER_W(AW)) dut (
        .clk(clk), .rst(rst), .now(now), .en(en),
        .set_valid(set_valid), .set_flow_id(set_flow_id), .set_timer_amnt(set_timer_amnt),
        .clr_valid(clr_valid), .clr_flow_id(clr_flow_id),
        .to_valid(to_valid), .to_flow_id(to_flow_id), .to_ready(to_ready),
        .expired_cnt(expired_cnt), .armed_vec(armed_vec)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [N-1:0] m_armed;
    logic [31:0] m_dl [N];
    int m_ptr, m_fid;
    bit m_pend, m_rearm;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: one request slot, a flow table, and a scan pointer that advances on enabled SCAN cycles.
    task automatic model_step();
        logic [N-1:0] na;
        bit seen_set;
        int k;
        if (rst) begin
            m_armed = '0;
            for (int i = 0; i < N; i++) m_dl[i] = '0;
            m_ptr = 0; m_fid = 0; m_pend = 0; m_rearm = 0; m_cnt = 0;
            return;
        end
        na = m_armed;
        if (m_pend) begin
            seen_set = m_rearm || (set_valid && int'(set_flow_id) == m_fid);
            if (to_ready) begin
                m_pend = 0;
                m_cnt = m_cnt + 1;
                if (!seen_set) na[m_fid] = 1'b0;
                m_rearm = 0;
            end else m_rearm = seen_set;
        end else if (en) begin
            k = m_ptr;
            if (m_armed[k] && (now - m_dl[k]) < 32'h8000_0000 &&
                !(set_valid && int'(set_flow_id) == k) && !(clr_valid && int'(clr_flow_id) == k)) begin
                m_pend = 1;
                m_fid = k;
            end
            m_ptr = (k + 1) % N;
        end
        if (clr_valid) na[clr_flow_id] = 1'b0;
        if (set_valid) begin
            na[set_flow_id] = 1'b1;
            m_dl[set_flow_id] = now + set_timer_amnt;
        end
        m_armed = na;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        now = now + 1;
        chk("to_valid", 32'(to_valid), 32'(m_pend));
        chk("to_flow_id", 32'(to_flow_id), m_fid);
        chk("expired_cnt", expired_cnt, m_cnt);
        chk("armed_vec", 32'(armed_vec), 32'(m_armed));
    endtask

    task automatic arm(input int f, input int a);
        set_valid = 1; set_flow_id = IW'(f); set_timer_amnt = AW'(a);
        tick();
        set_valid = 0;
    endtask

    task automatic disarm(input int f);
        clr_valid = 1; clr_flow_id = IW'(f);
        tick();
        clr_valid = 0;
    endtask

    task automatic wait_valid(input int maxc, output bit seen, output int cyc);
        seen = 0;
        cyc = 0;
        while (!seen && cyc < maxc) begin
            tick();
            cyc++;
            seen = to_valid;
        end
    endtask

    initial begin
        bit seen;
        int cyc, nreq;
        logic [IW-1:0] fid0;
        logic [31:0] base;
        rst = 1; en = 1; set_valid = 0; clr_valid = 0; to_ready = 1;
        set_flow_id = '0; clr_flow_id = '0; set_timer_amnt = '0; now = 100;
        tick(); tick();
        rst = 0;
        now = 100;
        arm(2, 10);
        wait_valid(30, seen, cyc);
        chk("t1_seen", 32'(seen), 1);
        chk("t1_fid", 32'(to_flow_id), 2);
        chk("t1_in_window", 32'(now >= 111 && now <= 116), 1);
        tick();
        chk("t1_cnt", expired_cnt, 1);
        chk("t1_disarmed", 32'(armed_vec[2]), 0);

        arm(1, 50);
        repeat (19) tick();
        disarm(1);
        nreq = 0;
        repeat (60) begin tick(); nreq += int'(to_valid); end
        chk("t2_no_req", nreq, 0);
        chk("t2_armed", 32'(armed_vec), 0);

        now = 32'hFFFF_FFF0;
        arm(0, 16'h20);
        nreq = 0;
        for (int i = 0; i < 64 && now != 32'h10; i++) begin tick(); nreq += int'(to_valid); end
        chk("t3_early", nreq, 0);
        wait_valid(5, seen, cyc);
        chk("t3_seen", 32'(seen), 1);
        chk("t3_fid", 32'(to_flow_id), 0);
        tick();

        to_ready = 0;
        base = expired_cnt;
        arm(0, 0);
        arm(3, 0);
        wait_valid(10, seen, cyc);
        chk("t4_seen", 32'(seen), 1);
        fid0 = to_flow_id;
        repeat (10) begin
            tick();
            chk("t4_hold_v", 32'(to_valid), 1);
            chk("t4_hold_id", 32'(to_flow_id), 32'(fid0));
        end
        to_ready = 1;
        tick();
        wait_valid(10, seen, cyc);
        chk("t4_second", 32'(seen), 1);
        chk("t4_second_id", 32'(to_flow_id), (fid0 == 0) ? 3 : 0);
        chk("t4_gap", 32'(cyc >= 1), 1);
        tick();
        chk("t4_cnt", expired_cnt, base + 2);

        to_ready = 0;
        arm(1, 0);
        wait_valid(10, seen, cyc);
        chk("t5_pend_id", 32'(to_flow_id), 1);
        arm(1, 30);
        repeat (3) tick();
        to_ready = 1;
        tick();
        chk("t5_rearmed", 32'(armed_vec[1]), 1);
        wait_valid(40, seen, cyc);
        chk("t5_second", 32'(seen), 1);
        chk("t5_second_id", 32'(to_flow_id), 1);
        chk("t5_delay", 32'(cyc >= 20), 1);
        tick();

        set_valid = 1; set_flow_id = 2; set_timer_amnt = 5;
        clr_valid = 1; clr_flow_id = 2;
        tick();
        set_valid = 0; clr_valid = 0;
        chk("t6_set_wins", 32'(armed_vec[2]), 1);
        to_ready = 0;
        wait_valid(20, seen, cyc);
        chk("t6_seen", 32'(seen), 1);
        rst = 1;
        tick();
        rst = 0;
        chk("t6_rst_valid", 32'(to_valid), 0);
        chk("t6_rst_armed", 32'(armed_vec), 0);
        chk("t6_rst_cnt", expired_cnt, 0);

        repeat (600) begin
            en = $urandom_range(0, 3) != 0;
            set_valid = $urandom_range(0, 3) == 0;
            set_flow_id = IW'($urandom);
            set_timer_amnt = AW'($urandom_range(0, 40));
            clr_valid = $urandom_range(0, 5) == 0;
            clr_flow_id = IW'($urandom);
            to_ready = $urandom_range(0, 2) != 0;
            rst = $urandom_range(0, 149) == 0;
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
